dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (one write port, combinational read) between NREQ requesters, e.g. the CPU data port and a DMA or debug loader.
- Each cycle the arbiter grants at most one request using round-robin priority, with an optional bounded lock for back-to-back bursts.
- It drives the memory's we/a/wd pins directly and returns registered responses, so read data, write acks and error flags arrive one cycle after the grant.
- Sits between the requesters and dmem.

Parameters:
NREQ, 2, number of requesters (2..4)
DEPTH_WORDS, 64, implemented memory depth in 32-bit words
LOCK_MAX, 4, maximum consecutive grants to one locking requester

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  request present, per requester
req_lock  input  NREQ  requester asks to keep the grant for its next request
req_we  input  NREQ  1 = write, 0 = read
req_addr  input  NREQ x 32  byte address
req_wdata  input  NREQ x 32  write data
req_ready  output  NREQ  one-hot grant; a transfer happens when valid && ready
rsp_valid  output  NREQ  one-hot response strobe, one cycle after the grant
rsp_rdata  output  32  read data (0 for writes and errors)
rsp_err  output  1  the response was an error access
mem_we  output  1  to dmem we
mem_a  output  32  to dmem a
mem_wd  output  32  to dmem wd
mem_rd  input  32  from dmem rd (combinational)

Behaviour:
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - mem_we = 0, mem_a = 0, mem_wd = 0.
  - prio_ptr = 0, state = ARB, lock_cnt = 0.
  - While reset is high no grant is given, even if req_valid is asserted.
- Grant selection (combinational):
  - In ARB, scan requesters from prio_ptr upward, modulo NREQ. The first one with req_valid set wins.
  - In LOCKED, the lock owner wins if its req_valid is set. Otherwise fall back to the ARB scan.
  - req_ready is one-hot on the winner and all-zero when no requester is valid.
  - req_ready does not depend on rsp_* state. The arbiter never stalls a winner.
- Memory drive (same cycle as the grant):
  - mem_a = winner addr, mem_wd = winner wdata.
  - mem_we = winner we && !err.
  - With no grant: mem_we = 0, and mem_a/mem_wd hold their previous values.
- Error condition:
  - err = addr[1:0] != 0, OR addr[31:2] >= DEPTH_WORDS.
  - An error access never writes memory. It still completes with a response.
- Response (registered, latency 1):
  - On the edge after a grant: rsp_valid is set only for the winner's bit.
  - rsp_rdata = mem_rd sampled at that edge for a good read; 0 for a write or an error.
  - rsp_err = err.
  - The cycle after that, rsp_valid returns to 0 unless a new grant occurred.
  - Back-to-back grants therefore give back-to-back responses.
- State machine:
  - ARB -> LOCKED: on a grant with req_lock[winner] = 1 and LOCK_MAX > 1. Set owner = winner, lock_cnt = 1.
  - LOCKED, owner granted with lock still set and lock_cnt + 1 < LOCK_MAX: stay in LOCKED, lock_cnt++.
  - LOCKED, owner granted and lock_cnt + 1 == LOCK_MAX: go to ARB. This forces rotation so others cannot starve.
  - LOCKED, owner granted with lock = 0: go to ARB.
  - LOCKED, owner not valid in a cycle: go to ARB and do not count that cycle.
- Priority pointer:
  - On any grant, prio_ptr <= (winner + 1) mod NREQ.
  - With no grant, prio_ptr is unchanged.
- Simultaneous events:
  - All requesters valid in ARB: strict rotation, each served within NREQ grants.
  - A lock request by a non-owner while LOCKED is ignored until it wins in ARB.
- Reset mid-operation:
  - Any pending response is dropped; rsp_valid = 0 on the next edge.
  - State returns to ARB and prio_ptr to 0.
  - mem_we is forced to 0 during reset cycles.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (ARB, LOCKED);
  - the default NREQ, DEPTH_WORDS and LOCK_MAX constants;
  - a function that computes err from an address and a depth.
- One sub-module, rr_pick: a combinational round-robin picker.
  - Inputs: a valid vector and prio_ptr.
  - Outputs: a one-hot grant and an any-valid flag.
  - Reused in both the ARB and the LOCKED fallback paths.

Test Plan:
- Reset with req_valid = 2'b11 held high -> req_ready = 0, mem_we = 0, rsp_valid = 0 throughout. After release, req0 is granted first (prio_ptr = 0).
- req0 writes 0x0000_0010 <= 0xDEADBEEF, then req1 reads 0x10 the next cycle -> mem_we pulses 1 for one cycle; rsp_valid = 01 then 10; the second response has rdata = 0xDEADBEEF, err = 0.
- Both valid for 4 cycles, no lock -> grants 01, 10, 01, 10; responses follow one cycle later in the same order.
- req0 valid with lock held, req1 valid, LOCK_MAX = 4 -> grants 01, 01, 01, 01, 10. No more than 4 consecutive grants to req0.
- req1 writes to 0x0000_0100 (word 64) and to 0x0000_0006 -> mem_we = 0 for both; rsp_err = 1, rsp_rdata = 0; a later read of word 1 returns its old value.
- Reset asserted on the cycle req1's read is granted -> no rsp_valid on the following edge; after release, state is ARB and prio_ptr = 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types, default sizing and the address-legality check for the
// data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   localparam int DEF_NREQ        = 2;
   localparam int DEF_DEPTH_WORDS = 64;
   localparam int DEF_LOCK_MAX    = 4;

   // A word access is legal only when aligned and inside the implemented depth.
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first valid requester at or after ptr
// (wrapping) wins.
module rr_pick #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          any_valid
);

   logic [PW-1:0] idx;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      grant = '0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(ptr) + i) % N);
         if (valid[idx] && (grant == '0)) grant[idx] = 1'b1;
      end
   end

   assign any_valid = |valid;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-port data memory between NREQ requesters,
// with bounded burst locking and one-cycle registered responses.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int NREQ        = DEF_NREQ,
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int LOCK_MAX    = DEF_LOCK_MAX
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_lock,
   input  logic [NREQ-1:0]       req_we,
   input  logic [NREQ-1:0][31:0] req_addr,
   input  logic [NREQ-1:0][31:0] req_wdata,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_we,
   output logic [31:0]           mem_a,
   output logic [31:0]           mem_wd,
   input  logic [31:0]           mem_rd
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(LOCK_MAX + 1);

   arb_state_e    state;
   logic [PW-1:0] owner;
   logic [CW-1:0] lock_cnt;
   logic [PW-1:0] prio_ptr;
   logic [31:0]   mem_a_q;
   logic [31:0]   mem_wd_q;

   logic [NREQ-1:0] rr_grant;
   logic            rr_any;
   logic [NREQ-1:0] grant;
   logic            owner_hit;
   logic            any_grant;
   logic [PW-1:0]   win_idx;
   logic            win_we;
   logic            win_err;
   logic [31:0]     win_addr;
   logic [31:0]     win_wdata;

   rr_pick #(.N(NREQ), .PW(PW)) u_pick (
      .valid     (req_valid),
      .ptr       (prio_ptr),
      .grant     (rr_grant),
      .any_valid (rr_any)
   );

   // A valid lock owner pre-empts the rotation; otherwise the picker decides.
   assign owner_hit = (state == LOCKED) && req_valid[owner];
   assign any_grant = !reset && (owner_hit || rr_any);

   always_comb begin
      grant   = '0;
      win_idx = '0;
      if (!reset) grant = owner_hit ? (NREQ'(1) << owner) : rr_grant;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) win_idx = PW'(i);
      end
   end

   assign win_addr  = req_addr[win_idx];
   assign win_wdata = req_wdata[win_idx];
   assign win_we    = req_we[win_idx];
   assign win_err   = addr_err(win_addr, DEPTH_WORDS);

   assign req_ready = grant;
   assign mem_we    = any_grant && win_we && !win_err;
   assign mem_a     = any_grant ? win_addr  : mem_a_q;
   assign mem_wd    = any_grant ? win_wdata : mem_wd_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state     <= ARB;
         owner     <= '0;
         lock_cnt  <= '0;
         prio_ptr  <= '0;
         mem_a_q   <= '0;
         mem_wd_q  <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= grant;
         rsp_rdata <= (any_grant && !win_we && !win_err) ? mem_rd : 32'h0;
         rsp_err   <= any_grant && win_err;

         if (any_grant) begin
            prio_ptr <= PW'((int'(win_idx) + 1) % NREQ);
            mem_a_q  <= win_addr;
            mem_wd_q <= win_wdata;
         end

         case (state)
            ARB: begin
               if (any_grant && req_lock[win_idx] && (LOCK_MAX > 1)) begin
                  state    <= LOCKED;
                  owner    <= win_idx;
                  lock_cnt <= CW'(1);
               end
            end
            LOCKED: begin
               // Leaving on the LOCK_MAX-th grant forces rotation so nobody starves.
               if (!owner_hit || !req_lock[owner] || (int'(lock_cnt) + 1 >= LOCK_MAX)) begin
                  state    <= ARB;
                  lock_cnt <= '0;
               end else begin
                  lock_cnt <= lock_cnt + CW'(1);
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a behavioural 64-word data memory.
module tb_dmem_arbiter;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       req_valid;
   logic [1:0]       req_lock;
   logic [1:0]       req_we;
   logic [1:0][31:0] req_addr;
   logic [1:0][31:0] req_wdata;
   logic [1:0]       req_ready;
   logic [1:0]       rsp_valid;
   logic [31:0]      rsp_rdata;
   logic             rsp_err;
   logic             mem_we;
   logic [31:0]      mem_a;
   logic [31:0]      mem_wd;
   logic [31:0]      mem_rd;

   logic [31:0] mem [0:63];

   int errors = 0;
   int checks = 0;

   dmem_arbiter #(.NREQ(2), .DEPTH_WORDS(64), .LOCK_MAX(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_lock  (req_lock),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_we    (mem_we),
      .mem_a     (mem_a),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd)
   );

   always #5 clk = ~clk;

   // NOTE: the bench memory is preloaded once in an initial block; the arbiter itself holds no array to reset.
   initial for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
   always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;
   assign mem_rd = mem[mem_a[7:2]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Applies one cycle of stimulus mid-cycle and settles before the caller checks.
   task automatic set_in(input logic rst, input logic [1:0] v, input logic [1:0] lk,
                         input logic [1:0] we, input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1);
      @(negedge clk);
      reset        = rst;
      req_valid    = v;
      req_lock     = lk;
      req_we       = we;
      req_addr[0]  = a0;
      req_wdata[0] = d0;
      req_addr[1]  = a1;
      req_wdata[1] = d1;
      #1;
   endtask

   task automatic check_rsp(input string tag, input logic [1:0] v, input logic [31:0] rd,
                            input logic err);
      check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v));
      check({tag, ".rsp_rdata"}, rsp_rdata, rd);
      check({tag, ".rsp_err"}, 32'(rsp_err), 32'(err));
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 2'b11;
      req_lock  = 2'b00;
      req_we    = 2'b11;
      req_addr  = '0;
      req_wdata = '0;

      // Reset held with both requesters valid and writing: nothing may be granted.
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 2'b11, 2'b00, 2'b11, 32'h10, 32'h1, 32'h14, 32'h2);
         check("rst.ready", 32'(req_ready), 32'h0);
         check("rst.mem_we", 32'(mem_we), 32'h0);
         check("rst.rsp_valid", 32'(rsp_valid), 32'h0);
      end
      check("rst.mem_a", mem_a, 32'h0);

      // Release: prio_ptr is 0 so req0 wins first.
      set_in(1'b0, 2'b11, 2'b00, 2'b00, 32'h20, 32'h0, 32'h24, 32'h0);
      check("c1.ready", 32'(req_ready), 32'h1);
      check("c1.mem_a", mem_a, 32'h20);
      check("c1.mem_we", 32'(mem_we), 32'h0);

      // Write then read-back by the other requester.
      set_in(1'b0, 2'b01, 2'b00, 2'b01, 32'h10, 32'hDEAD_BEEF, 32'h0, 32'h0);
      check("wr.ready", 32'(req_ready), 32'h1);
      check("wr.mem_we", 32'(mem_we), 32'h1);
      check("wr.mem_a", mem_a, 32'h10);
      check("wr.mem_wd", mem_wd, 32'hDEAD_BEEF);
      check_rsp("c1rsp", 2'b01, 32'h1000_0008, 1'b0);

      set_in(1'b0, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 32'h10, 32'h0);
      check("rd.ready", 32'(req_ready), 32'h2);
      check("rd.mem_we", 32'(mem_we), 32'h0);
      check_rsp("wrrsp", 2'b01, 32'h0, 1'b0);

      // Both valid, no lock: strict alternation starting from req0.
      set_in(1'b0, 2'b11, 2'b00, 2'b00, 32'h04, 32'h0, 32'h08, 32'h0);
      check("rr0.ready", 32'(req_ready), 32'h1);
      check_rsp("rdrsp", 2'b10, 32'hDEAD_BEEF, 1'b0);
      set_in(1'b0, 2'b11, 2'b00, 2'b00, 32'h04, 32'h0, 32'h08, 32'h0);
      check("rr1.ready", 32'(req_ready), 32'h2);
      check_rsp("rr0rsp", 2'b01, 32'h1000_0001, 1'b0);
      set_in(1'b0, 2'b11, 2'b00, 2'b00, 32'h04, 32'h0, 32'h08, 32'h0);
      check("rr2.ready", 32'(req_ready), 32'h1);
      check_rsp("rr1rsp", 2'b10, 32'h1000_0002, 1'b0);
      set_in(1'b0, 2'b11, 2'b00, 2'b00, 32'h04, 32'h0, 32'h08, 32'h0);
      check("rr3.ready", 32'(req_ready), 32'h2);
      check_rsp("rr2rsp", 2'b01, 32'h1000_0001, 1'b0);

      // req0 locks: four grants to req0, then forced rotation to req1.
      for (int i = 0; i < 4; i++) begin
         set_in(1'b0, 2'b11, 2'b01, 2'b00, 32'h04, 32'h0, 32'h08, 32'h0);
         check($sformatf("lock%0d.ready", i), 32'(req_ready), 32'h1);
         check($sformatf("lock%0d.rsp_valid", i), 32'(rsp_valid), (i == 0) ? 32'h2 : 32'h1);
      end
      set_in(1'b0, 2'b11, 2'b01, 2'b00, 32'h04, 32'h0, 32'h08, 32'h0);
      check("lock4.ready", 32'(req_ready), 32'h2);
      check("lock4.rsp_valid", 32'(rsp_valid), 32'h1);

      // Error writes: out of range and misaligned never reach memory.
      set_in(1'b0, 2'b10, 2'b00, 2'b10, 32'h0, 32'h0, 32'h100, 32'hCAFE_F00D);
      check("err0.ready", 32'(req_ready), 32'h2);
      check("err0.mem_we", 32'(mem_we), 32'h0);
      check_rsp("lock4rsp", 2'b10, 32'h1000_0002, 1'b0);
      set_in(1'b0, 2'b10, 2'b00, 2'b10, 32'h0, 32'h0, 32'h06, 32'hCAFE_F00D);
      check("err1.ready", 32'(req_ready), 32'h2);
      check("err1.mem_we", 32'(mem_we), 32'h0);
      check_rsp("err0rsp", 2'b10, 32'h0, 1'b1);
      set_in(1'b0, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 32'h04, 32'h0);
      check("rdw1.ready", 32'(req_ready), 32'h2);
      check_rsp("err1rsp", 2'b10, 32'h0, 1'b1);

      // Idle cycle: address holds, response of word 1 carries its old value.
      set_in(1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      check("idle.ready", 32'(req_ready), 32'h0);
      check("idle.mem_a", mem_a, 32'h04);
      check("idle.mem_we", 32'(mem_we), 32'h0);
      check_rsp("rdw1rsp", 2'b10, 32'h1000_0001, 1'b0);

      // req1 takes a lock, then reset lands on its next read.
      set_in(1'b0, 2'b10, 2'b10, 2'b00, 32'h0, 32'h0, 32'h08, 32'h0);
      check("pre.ready", 32'(req_ready), 32'h2);
      check("idle.rsp_valid", 32'(rsp_valid), 32'h0);
      set_in(1'b1, 2'b10, 2'b10, 2'b00, 32'h0, 32'h0, 32'h0C, 32'h0);
      check("rstmid.ready", 32'(req_ready), 32'h0);
      check("rstmid.mem_we", 32'(mem_we), 32'h0);
      check_rsp("prersp", 2'b10, 32'h1000_0002, 1'b0);
      set_in(1'b0, 2'b11, 2'b00, 2'b00, 32'h0C, 32'h0, 32'h10, 32'h0);
      check("post.rsp_valid", 32'(rsp_valid), 32'h0);
      check("post.ready", 32'(req_ready), 32'h1);
      set_in(1'b0, 2'b11, 2'b00, 2'b00, 32'h0C, 32'h0, 32'h10, 32'h0);
      check("post1.ready", 32'(req_ready), 32'h2);
      check_rsp("postrsp", 2'b01, 32'h1000_0003, 1'b0);

      set_in(1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
